// File: rtl/iiitb_fifo.sv
// iiitb_fifo: single-clock synchronous FIFO, 2^BUF_WIDTH entries of DATA_WIDTH
// bits, with a registered read-data output.
//   clk          : system clock, all state updates on the rising edge
//   rst          : asynchronous active-low reset
//   buf_in       : write data
//   wr_en/rd_en  : write / read requests
//   buf_out      : registered read data, holds when no read is accepted
//   buf_empty    : occupancy == 0
//   buf_full     : occupancy == 2^BUF_WIDTH
//   fifo_counter : current occupancy, 0..2^BUF_WIDTH
module iiitb_fifo #(
  parameter int BUF_WIDTH  = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] buf_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] buf_out,
  output logic                  buf_empty,
  output logic                  buf_full,
  output logic [BUF_WIDTH:0]    fifo_counter
);

  localparam int                DEPTH_I = 1 << BUF_WIDTH;
  localparam logic [BUF_WIDTH:0] DEPTH  = (BUF_WIDTH+1)'(DEPTH_I);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_I];

  logic [BUF_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [BUF_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [BUF_WIDTH:0]    cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] buf_out_q, buf_out_d;
  logic                  wr_ok, rd_ok;

  // Flags come straight from the counter; pointers alone cannot tell
  // full from empty since they wrap onto each other.
  assign buf_empty    = (cnt_q == '0);
  assign buf_full     = (cnt_q == DEPTH);
  assign fifo_counter = cnt_q;
  assign buf_out      = buf_out_q;

  assign wr_ok = wr_en && !buf_full;
  assign rd_ok = rd_en && !buf_empty;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    buf_out_d = buf_out_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      buf_out_d = mem_q[rd_ptr_q];
    end
    case ({wr_ok, rd_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      buf_out_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      buf_out_q <= buf_out_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= buf_in;
  end

endmodule

// File: tb/tb_iiitb_fifo.sv
module tb_iiitb_fifo;

  logic       clk;
  logic       rst;
  logic [7:0] buf_in;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] buf_out;
  logic       buf_empty;
  logic       buf_full;
  logic [3:0] fifo_counter;

  int checks = 0;
  int errors = 0;

  iiitb_fifo #(.BUF_WIDTH(3), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .buf_in(buf_in), .wr_en(wr_en), .rd_en(rd_en),
    .buf_out(buf_out), .buf_empty(buf_empty), .buf_full(buf_full),
    .fifo_counter(fifo_counter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of requests, then sample 1ns after the edge.
  task automatic cyc(input logic w, input logic r, input logic [7:0] d);
    wr_en  = w;
    rd_en  = r;
    buf_in = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_seq [8];
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; buf_in = '0;
    #12;
    chk("rst_cnt",   fifo_counter, 0);
    chk("rst_empty", buf_empty, 1);
    chk("rst_full",  buf_full, 0);
    chk("rst_out",   buf_out, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: single write, then write+read together
    cyc(1, 0, 8'd1);
    chk("t1_cnt",   fifo_counter, 1);
    chk("t1_empty", buf_empty, 0);
    cyc(1, 1, 8'd2);
    chk("t1_wr_rd_out", buf_out, 1);
    chk("t1_wr_rd_cnt", fifo_counter, 1);

    // 2: fill, then overflow attempts
    for (int i = 1; i <= 7; i++) cyc(1, 0, 8'(i * 10));
    chk("t2_cnt_full", fifo_counter, 8);
    chk("t2_full",     buf_full, 1);
    for (int i = 8; i <= 13; i++) cyc(1, 0, 8'(i * 10));
    chk("t2_ovf_cnt",  fifo_counter, 8);
    chk("t2_ovf_full", buf_full, 1);

    // 3: drain across the pointer wrap
    exp_seq = '{8'd2, 8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70};
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 8'd0);
      chk($sformatf("t3_rd%0d", i), buf_out, exp_seq[i]);
    end
    chk("t3_cnt",   fifo_counter, 0);
    chk("t3_empty", buf_empty, 1);

    // 4: underflow holds, then write/read, then write+read when empty
    cyc(0, 1, 8'd0);
    chk("t4_unf_out", buf_out, 70);
    chk("t4_unf_cnt", fifo_counter, 0);
    cyc(1, 0, 8'd5);
    cyc(0, 1, 8'd0);
    chk("t4_rd5", buf_out, 5);
    cyc(1, 1, 8'd9);
    chk("t4_wr_rd_empty_out", buf_out, 5);
    chk("t4_wr_rd_empty_cnt", fifo_counter, 1);
    cyc(0, 1, 8'd0);
    chk("t4_rd9", buf_out, 9);

    // 5: write+read when full drops the write
    for (int i = 0; i < 8; i++) cyc(1, 0, 8'(100 + i));
    chk("t5_full", buf_full, 1);
    cyc(1, 1, 8'd200);
    chk("t5_out", buf_out, 100);
    chk("t5_cnt", fifo_counter, 7);
    for (int i = 1; i < 8; i++) begin
      cyc(0, 1, 8'd0);
      chk($sformatf("t5_rd%0d", i), buf_out, 100 + i);
    end
    chk("t5_drained", fifo_counter, 0);

    // 6: asynchronous reset between edges
    for (int i = 0; i < 4; i++) cyc(1, 0, 8'(40 + i));
    chk("t6_cnt4", fifo_counter, 4);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_async_cnt",   fifo_counter, 0);
    chk("t6_async_empty", buf_empty, 1);
    chk("t6_async_out",   buf_out, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    cyc(1, 0, 8'h55);
    cyc(0, 1, 8'd0);
    chk("t6_post_rst_rd", buf_out, 8'h55);
    chk("t6_post_rst_cnt", fifo_counter, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
